// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: pipelined integer execution unit with valid/ready handshakes, flush and completion counter
module alu_exec_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int LAT   = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_op,
  input  logic [XLEN-1:0]  issue_src1,
  input  logic [XLEN-1:0]  issue_src2,
  input  logic [XLEN-1:0]  issue_imm,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_illegal,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);
  localparam int SH_W = $clog2(XLEN);
  logic [LAT-1:0]   r_v;
  logic [LAT-1:0]   r_il;
  logic [XLEN-1:0]  r_d [LAT];
  logic [TAG_W-1:0] r_t [LAT];
  logic             w_adv;
  logic             w_acc;
  logic             w_il;
  logic [XLEN-1:0]  w_res;
  logic [XLEN-1:0]  w_sum_imm;
  assign w_adv       = !r_v[LAT-1] | res_ready;
  assign issue_ready = w_adv & !flush & rstn;
  assign w_acc       = issue_valid & issue_ready;
  assign w_sum_imm   = issue_src1 + issue_imm;
  assign res_valid   = r_v[LAT-1];
  assign res_data    = r_d[LAT-1];
  assign res_tag     = r_t[LAT-1];
  assign res_illegal = r_il[LAT-1];
  assign busy        = |r_v;
  // decode and compute the result at issue; undefined opcodes yield zero and are flagged
  always_comb begin
    w_res = '0;
    w_il  = 1'b0;
    case (issue_op)
      4'd1:                    w_res = issue_src1 + issue_src2;
      4'd2, 4'd7, 4'd8, 4'd9,
      4'd10:                   w_res = w_sum_imm;
      4'd3:                    w_res = issue_imm << 12;
      4'd4:                    w_res = issue_src1 | issue_imm;
      4'd5:                    w_res = issue_src1 ^ issue_src2;
      4'd6:                    w_res = $signed(issue_src1) >>> issue_imm[SH_W-1:0];
      4'd11:                   w_res = issue_src1 - issue_src2;
      4'd12:                   w_res = issue_src1 & issue_src2;
      4'd13:                   w_res = {{(XLEN-1){1'b0}}, $signed(issue_src1) < $signed(issue_src2)};
      default:                 w_il  = 1'b1;
    endcase
  end
  // stage registers: global shift on advance, flush clears only the valids
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_v  <= '0;
      r_il <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_d[i] <= '0;
        r_t[i] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else if (w_adv) begin
      r_v[0]  <= w_acc;
      r_il[0] <= w_il;
      r_d[0]  <= w_res;
      r_t[0]  <= issue_tag;
      for (int i = 1; i < LAT; i++) begin
        r_v[i]  <= r_v[i-1];
        r_il[i] <= r_il[i-1];
        r_d[i]  <= r_d[i-1];
        r_t[i]  <= r_t[i-1];
      end
    end
  end
  // count result handshakes that are not killed by a same-cycle flush
  always_ff @(posedge clk) begin
    if (!rstn) done_cnt <= '0;
    else if (!flush && res_valid && res_ready) done_cnt <= done_cnt + CNT_W'(1);
  end
endmodule
